// File: rtl/w0rm_gpio_pkg.sv
// Shared constants for the W0RM GPIO/IRQ peripheral: register map and register-index decode.
package w0rm_gpio_pkg;

  localparam int WINDOW_BYTES = 64;
  localparam int OFS_BITS     = $clog2(WINDOW_BYTES);

  localparam logic [OFS_BITS-1:0] OFS_OUT      = 6'h00;
  localparam logic [OFS_BITS-1:0] OFS_DIR      = 6'h04;
  localparam logic [OFS_BITS-1:0] OFS_IN       = 6'h08;
  localparam logic [OFS_BITS-1:0] OFS_OUT_SET  = 6'h0C;
  localparam logic [OFS_BITS-1:0] OFS_OUT_CLR  = 6'h10;
  localparam logic [OFS_BITS-1:0] OFS_RISE_EN  = 6'h14;
  localparam logic [OFS_BITS-1:0] OFS_FALL_EN  = 6'h18;
  localparam logic [OFS_BITS-1:0] OFS_IRQ_STAT = 6'h1C;

  typedef enum logic [3:0] {
    REG_OUT,
    REG_DIR,
    REG_IN,
    REG_OUT_SET,
    REG_OUT_CLR,
    REG_RISE_EN,
    REG_FALL_EN,
    REG_IRQ_STAT,
    REG_NONE
  } reg_idx_e;

  // Only exact word offsets map; anything else in the window is a hole.
  function automatic reg_idx_e decode_offset(input logic [OFS_BITS-1:0] ofs);
    case (ofs)
      OFS_OUT:      return REG_OUT;
      OFS_DIR:      return REG_DIR;
      OFS_IN:       return REG_IN;
      OFS_OUT_SET:  return REG_OUT_SET;
      OFS_OUT_CLR:  return REG_OUT_CLR;
      OFS_RISE_EN:  return REG_RISE_EN;
      OFS_FALL_EN:  return REG_FALL_EN;
      OFS_IRQ_STAT: return REG_IRQ_STAT;
      default:      return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/w0rm_gpio_sync_edge.sv
// Multi-stage pad synchroniser with a previous-value register for edge detection.
module w0rm_gpio_sync_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_d, chain_q;
  logic [WIDTH-1:0]                  prev_d, prev_q;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], async_i};
    prev_d  = chain_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      prev_q  <= '0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];
  assign rise_o = chain_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~chain_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/w0rm_peripheral_gpio_irq.sv
// W0RM GPIO peripheral with per-pin direction, atomic set/clear and edge interrupts.
// Interrupt logic (RISE_EN, FALL_EN, IRQ_STAT, prime counter) is built only with W0RM_GPIO_IRQ_EN.
module w0rm_peripheral_gpio_irq
  import w0rm_gpio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    GPIO_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h80000040,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  mem_clk,
  input  logic                  cpu_reset_n,
  input  logic                  mem_valid_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  mem_valid_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  inout  wire  [GPIO_WIDTH-1:0] pin_gpio_pad,
  output logic                  irq_o
);

  logic                  hit, wr_hit;
  reg_idx_e              reg_idx;
  logic [GPIO_WIDTH-1:0] wdata, rd_val;
  logic [GPIO_WIDTH-1:0] out_d, out_q, dir_d, dir_q;
  logic                  resp_valid_d, resp_valid_q;
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic [GPIO_WIDTH-1:0] in_sync, edge_rise, edge_fall;
  logic                  unused_data;

  assign unused_data = ^mem_data_i;

  w0rm_gpio_sync_edge #(
    .WIDTH       (GPIO_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (mem_clk),
    .rst_n   (cpu_reset_n),
    .async_i (pin_gpio_pad),
    .sync_o  (in_sync),
    .rise_o  (edge_rise),
    .fall_o  (edge_fall)
  );

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pad
    assign pin_gpio_pad[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

`ifdef W0RM_GPIO_IRQ_EN
  localparam int PRIME_CYCLES = SYNC_STAGES + 1;

  logic [GPIO_WIDTH-1:0] rise_en_d, rise_en_q, fall_en_d, fall_en_q;
  logic [GPIO_WIDTH-1:0] stat_d, stat_q, stat_clr, stat_evt;
  logic                  irq_d, irq_q;
  logic [2:0]            prime_cnt_d, prime_cnt_q;
  logic                  primed;
`else
  logic                  unused_edges;
  assign unused_edges = ^{edge_rise, edge_fall};
`endif

  always_comb begin
    hit     = mem_valid_i && (mem_read_i || mem_write_i) &&
              (mem_addr_i[ADDR_WIDTH-1:OFS_BITS] == BASE_ADDR[ADDR_WIDTH-1:OFS_BITS]);
    wr_hit  = hit && mem_write_i;
    reg_idx = decode_offset(mem_addr_i[OFS_BITS-1:0]);
    wdata   = mem_data_i[GPIO_WIDTH-1:0];

    rd_val = '0;
    case (reg_idx)
      REG_OUT:      rd_val = out_q;
      REG_DIR:      rd_val = dir_q;
      REG_IN:       rd_val = in_sync;
`ifdef W0RM_GPIO_IRQ_EN
      REG_RISE_EN:  rd_val = rise_en_q;
      REG_FALL_EN:  rd_val = fall_en_q;
      REG_IRQ_STAT: rd_val = stat_q;
`endif
      default:      rd_val = '0;
    endcase

    // Read data comes from the current registers, so a combined read+write returns pre-write state.
    resp_valid_d = hit;
    rdata_d      = (hit && mem_read_i) ? DATA_WIDTH'(rd_val) : '0;

    out_d = out_q;
    dir_d = dir_q;
    if (wr_hit) begin
      case (reg_idx)
        REG_OUT:     out_d = wdata;
        REG_OUT_SET: out_d = out_q | wdata;
        REG_OUT_CLR: out_d = out_q & ~wdata;
        REG_DIR:     dir_d = wdata;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      out_q        <= '0;
      dir_q        <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      out_q        <= out_d;
      dir_q        <= dir_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign mem_valid_o = resp_valid_q;
  assign mem_data_o  = rdata_q;

`ifdef W0RM_GPIO_IRQ_EN
  // Edges are ignored until the synchroniser has flushed its reset zeros, plus one for prev_q.
  always_comb begin
    primed      = (prime_cnt_q == 3'(PRIME_CYCLES));
    prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + 3'd1;

    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    stat_clr  = '0;
    if (wr_hit) begin
      case (reg_idx)
        REG_RISE_EN:  rise_en_d = wdata;
        REG_FALL_EN:  fall_en_d = wdata;
        REG_IRQ_STAT: stat_clr  = wdata;
        default:      ;
      endcase
    end

    // A new event in the same cycle as a clear keeps the bit set.
    stat_evt = primed ? ((edge_rise & rise_en_q) | (edge_fall & fall_en_q)) : '0;
    stat_d   = (stat_q & ~stat_clr) | stat_evt;
    irq_d    = |stat_q;
  end

  always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      rise_en_q   <= '0;
      fall_en_q   <= '0;
      stat_q      <= '0;
      irq_q       <= 1'b0;
      prime_cnt_q <= '0;
    end else begin
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      stat_q      <= stat_d;
      irq_q       <= irq_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_w0rm_peripheral_gpio_irq.sv
// Scoreboard bench for w0rm_peripheral_gpio_irq; IRQ checks follow W0RM_GPIO_IRQ_EN.
module tb_w0rm_peripheral_gpio_irq;

  localparam logic [31:0] BASE     = 32'h80000040;
  localparam logic [31:0] A_OUT    = BASE + 32'h00;
  localparam logic [31:0] A_DIR    = BASE + 32'h04;
  localparam logic [31:0] A_IN     = BASE + 32'h08;
  localparam logic [31:0] A_SET    = BASE + 32'h0C;
  localparam logic [31:0] A_CLR    = BASE + 32'h10;
  localparam logic [31:0] A_RISE   = BASE + 32'h14;
  localparam logic [31:0] A_FALL   = BASE + 32'h18;
  localparam logic [31:0] A_STAT   = BASE + 32'h1C;
  localparam logic [31:0] A_HOLE   = BASE + 32'h20;
  localparam logic [31:0] A_MISS   = 32'h80000080;

  logic        mem_clk = 1'b0;
  logic        cpu_reset_n;
  logic        mem_valid_i, mem_read_i, mem_write_i;
  logic [31:0] mem_addr_i, mem_data_i;
  logic        mem_valid_o;
  logic [31:0] mem_data_o;
  logic        irq_o;
  wire  [7:0]  pin_gpio_pad;
  logic [7:0]  tb_oe, tb_val;

  int          checks   = 0;
  int          failures = 0;
  int          resp_idx = 0;
  logic [31:0] exp_q[$];

  for (genvar i = 0; i < 8; i++) begin : g_tb_pad
    assign pin_gpio_pad[i] = tb_oe[i] ? tb_val[i] : 1'bz;
  end

  w0rm_peripheral_gpio_irq #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .GPIO_WIDTH  (8),
    .BASE_ADDR   (32'h80000040),
    .SYNC_STAGES (2)
  ) dut (
    .mem_clk      (mem_clk),
    .cpu_reset_n  (cpu_reset_n),
    .mem_valid_i  (mem_valid_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .mem_addr_i   (mem_addr_i),
    .mem_data_i   (mem_data_i),
    .mem_valid_o  (mem_valid_o),
    .mem_data_o   (mem_data_o),
    .pin_gpio_pad (pin_gpio_pad),
    .irq_o        (irq_o)
  );

  initial forever #5 mem_clk = ~mem_clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: responses are popped from the scoreboard; idle cycles must present zero data.
  always @(negedge mem_clk) begin
    logic [31:0] e;
    if (mem_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_resp: got valid=1 data=%h expected no response", mem_data_o);
      end else begin
        e = exp_q.pop_front();
        checkOutput($sformatf("resp%0d", resp_idx), mem_data_o, e);
        resp_idx++;
      end
    end else begin
      checkOutput("idle_data", mem_data_o, 32'h0);
    end
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic exp_resp,
                               input logic [31:0] exp_data);
    @(negedge mem_clk);
    mem_valid_i = 1'b1;
    mem_read_i  = rd;
    mem_write_i = wr;
    mem_addr_i  = addr;
    mem_data_i  = data;
    if (exp_resp) exp_q.push_back(exp_data);
    @(posedge mem_clk);
    #1;
    mem_valid_i = 1'b0;
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] addr, input logic [31:0] exp);
    applyStimulus(1'b1, 1'b0, addr, 32'h0, 1'b1, exp);
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b0, 1'b1, addr, data, 1'b1, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge mem_clk);
    #1;
  endtask

  initial begin
    cpu_reset_n = 1'b0;
    mem_valid_i = 1'b0;
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    mem_addr_i  = '0;
    mem_data_i  = '0;
    tb_oe       = 8'hFF;
    tb_val      = 8'h00;

    idle(3);
    checkOutput("rst_valid", {31'b0, mem_valid_o}, 32'h0);
    checkOutput("rst_data", mem_data_o, 32'h0);
    checkOutput("rst_irq", {31'b0, irq_o}, 32'h0);
    cpu_reset_n = 1'b1;

    // Reset values and window decode
    busRead(A_OUT, 32'h0);
    applyStimulus(1'b1, 1'b0, A_MISS, 32'h0, 1'b0, 32'h0);
    busRead(A_DIR, 32'h0);

    // Output control
    tb_oe = 8'h00;
    busWrite(A_DIR, 32'h000000FF);
    busWrite(A_OUT, 32'h0000000F);
    busWrite(A_SET, 32'h000000F0);
    busWrite(A_CLR, 32'h00000001);
    checkOutput("pads_fe", {24'b0, pin_gpio_pad}, 32'h000000FE);
    busRead(A_OUT, 32'h000000FE);
    busRead(A_SET, 32'h0);
    applyStimulus(1'b1, 1'b1, A_OUT, 32'hABCDEF33, 1'b1, 32'h000000FE);
    busRead(A_OUT, 32'h00000033);
    checkOutput("pads_33", {24'b0, pin_gpio_pad}, 32'h00000033);
    busRead(A_HOLE, 32'h0);
    busWrite(A_HOLE, 32'hFFFFFFFF);
    busRead(A_IN, 32'h00000033);

    // Input synchronisation, two stages
    busWrite(A_DIR, 32'h0);
    tb_oe  = 8'hFF;
    tb_val = 8'h00;
    idle(4);
    tb_val = 8'h5A;
    busRead(A_IN, 32'h0);
    busRead(A_IN, 32'h0);
    busRead(A_IN, 32'h0000005A);

`ifdef W0RM_GPIO_IRQ_EN
    // Rising-edge interrupt on pin 0
    busWrite(A_RISE, 32'h01);
    tb_val = 8'h5B;
    busRead(A_STAT, 32'h0);
    busRead(A_STAT, 32'h0);
    busRead(A_STAT, 32'h0);
    checkOutput("irq_before", {31'b0, irq_o}, 32'h0);
    busRead(A_STAT, 32'h01);
    checkOutput("irq_rise", {31'b0, irq_o}, 32'h1);
    busWrite(A_RISE, 32'h0);
    busRead(A_STAT, 32'h01);
    busWrite(A_STAT, 32'h01);
    checkOutput("irq_hold", {31'b0, irq_o}, 32'h1);
    idle(1);
    checkOutput("irq_clear", {31'b0, irq_o}, 32'h0);
    busRead(A_STAT, 32'h0);

    // Falling edge on pin 3 racing a W1C of the same bit
    busWrite(A_FALL, 32'h08);
    tb_val = 8'h53;
    idle(4);
    busRead(A_STAT, 32'h08);
    busRead(A_FALL, 32'h08);
    tb_val = 8'h5B;
    idle(4);
    tb_val = 8'h53;
    idle(2);
    busWrite(A_STAT, 32'h08);
    busRead(A_STAT, 32'h08);
    busWrite(A_STAT, 32'h08);
    busRead(A_STAT, 32'h0);
`else
    // Interrupt registers absent
    busWrite(A_RISE, 32'hFF);
    busRead(A_RISE, 32'h0);
    busRead(A_STAT, 32'h0);
    tb_val = 8'hA5;
    idle(5);
    checkOutput("irq_off_a", {31'b0, irq_o}, 32'h0);
    tb_val = 8'h5A;
    idle(5);
    checkOutput("irq_off_b", {31'b0, irq_o}, 32'h0);
`endif

    // Reset mid-transaction, then pads held high through release
    applyStimulus(1'b1, 1'b0, A_OUT, 32'h0, 1'b0, 32'h0);
    cpu_reset_n = 1'b0;
    tb_val = 8'hFF;
    idle(3);
    checkOutput("rst2_valid", {31'b0, mem_valid_o}, 32'h0);
    checkOutput("rst2_irq", {31'b0, irq_o}, 32'h0);
    cpu_reset_n = 1'b1;
    busWrite(A_RISE, 32'hFF);
    idle(6);
    busRead(A_STAT, 32'h0);
    checkOutput("prime_irq", {31'b0, irq_o}, 32'h0);
    busRead(A_DIR, 32'h0);
    busRead(A_OUT, 32'h0);
    busRead(A_IN, 32'h000000FF);

    idle(2);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
